// File: rtl/lfsr_if.sv
// Control/status bundle for the LFSR generator: seed/step/burst requests in, state and pulses out.
interface lfsr_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] seed_i;
    logic             load_i;
    logic             en_i;
    logic             burst_i;
    logic [CNT_W-1:0] burst_len_i;
    logic [WIDTH-1:0] state_o;
    logic             busy_o;
    logic             done_o;
    logic             wrap_o;
    logic             lock_o;
    logic [WIDTH-1:0] step_cnt_o;

    modport master (
        output seed_i, load_i, en_i, burst_i, burst_len_i,
        input  state_o, busy_o, done_o, wrap_o, lock_o, step_cnt_o
    );

    modport slave (
        input  seed_i, load_i, en_i, burst_i, burst_len_i,
        output state_o, busy_o, done_o, wrap_o, lock_o, step_cnt_o
    );
endinterface

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with seed load (lock-up protected), single/burst stepping and period-wrap detection.
//  state | meaning
//  IDLE  | steps only on en_i; accepts load_i and burst_i
//  BURST | one step per cycle until the burst counter expires; load_i aborts
module lfsr_gen #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
    parameter bit               XNOR_MODE  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_SEED = 8'h01,
    parameter int               CNT_W      = 8
) (
    input  logic  clk,
    input  logic  reset,
    lfsr_if.slave bus
);
    typedef enum logic {IDLE, BURST} fsm_t;

    // The lock-up value never leaves itself, so a seed equal to it is swapped for a safe one.
    localparam logic [WIDTH-1:0] LOCK_VAL = XNOR_MODE ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] SUB_VAL  = XNOR_MODE ? {WIDTH{1'b0}} : {{(WIDTH-1){1'b0}}, 1'b1};

    fsm_t             fsm_q, fsm_n;
    logic [WIDTH-1:0] state_q, state_n;
    logic [WIDTH-1:0] seed_q, seed_n;
    logic [WIDTH-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] rem_q, rem_n;
    logic             done_q, done_n;
    logic             wrap_q, wrap_n;
    logic             lock_q, lock_n;
    logic             do_step;
    logic             fb;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        fb       = XNOR_MODE ? ~^(state_q & TAPS) : ^(state_q & TAPS);
        step_val = {state_q[WIDTH-2:0], fb};
        load_val = (bus.seed_i == LOCK_VAL) ? SUB_VAL : bus.seed_i;
    end

    always_comb begin
        fsm_n   = fsm_q;
        state_n = state_q;
        seed_n  = seed_q;
        cnt_n   = cnt_q;
        rem_n   = rem_q;
        done_n  = 1'b0;
        wrap_n  = 1'b0;
        lock_n  = 1'b0;
        do_step = 1'b0;

        if (bus.load_i) begin
            state_n = load_val;
            seed_n  = load_val;
            cnt_n   = '0;
            lock_n  = (bus.seed_i == LOCK_VAL);
            fsm_n   = IDLE;
            rem_n   = '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (bus.burst_i) begin
                        if (bus.burst_len_i == '0) begin
                            done_n = 1'b1;
                        end else begin
                            do_step = 1'b1;
                            // A one-step burst finishes on its first edge and never shows busy.
                            if (bus.burst_len_i == CNT_W'(1)) begin
                                done_n = 1'b1;
                            end else begin
                                fsm_n = BURST;
                                rem_n = bus.burst_len_i - 1'b1;
                            end
                        end
                    end else if (bus.en_i) begin
                        do_step = 1'b1;
                    end
                end
                BURST: begin
                    do_step = 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        fsm_n  = IDLE;
                        rem_n  = '0;
                        done_n = 1'b1;
                    end else begin
                        rem_n = rem_q - 1'b1;
                    end
                end
                default: fsm_n = IDLE;
            endcase
        end

        if (do_step) begin
            state_n = step_val;
            if (step_val == seed_q) begin
                wrap_n = 1'b1;
                cnt_n  = '0;
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= RESET_SEED;
            seed_q  <= RESET_SEED;
            cnt_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_n;
            state_q <= state_n;
            seed_q  <= seed_n;
            cnt_q   <= cnt_n;
            rem_q   <= rem_n;
            done_q  <= done_n;
            wrap_q  <= wrap_n;
            lock_q  <= lock_n;
        end
    end

    assign bus.state_o    = state_q;
    assign bus.busy_o     = (fsm_q == BURST);
    assign bus.done_o     = done_q;
    assign bus.wrap_o     = wrap_q;
    assign bus.lock_o     = lock_q;
    assign bus.step_cnt_o = cnt_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: the driver queues hand-computed expectations, a monitor compares each cycle.
module tb_lfsr_gen;
    logic clk;
    logic reset;

    lfsr_if #(.WIDTH(8), .CNT_W(8)) bus ();

    lfsr_gen #(
        .WIDTH(8), .TAPS(8'hB8), .XNOR_MODE(1'b1), .RESET_SEED(8'h01), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // chk bits: 0 state, 1 busy, 2 done, 3 wrap, 4 lock, 5 step count
    typedef struct packed {
        logic [7:0] st;
        logic       busy;
        logic       done;
        logic       wrap;
        logic       lock;
        logic [7:0] cnt;
        logic [5:0] chk;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passed = 0;

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s %s: got %0h expected %0h", nm, fld, act, req);
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (e.chk[0]) cmp(n, "state", int'(bus.state_o), int'(e.st));
            if (e.chk[1]) cmp(n, "busy", int'(bus.busy_o), int'(e.busy));
            if (e.chk[2]) cmp(n, "done", int'(bus.done_o), int'(e.done));
            if (e.chk[3]) cmp(n, "wrap", int'(bus.wrap_o), int'(e.wrap));
            if (e.chk[4]) cmp(n, "lock", int'(bus.lock_o), int'(e.lock));
            if (e.chk[5]) cmp(n, "step_cnt", int'(bus.step_cnt_o), int'(e.cnt));
        end
    end

    task automatic cyc(input logic rst, input logic ld, input logic [7:0] sd, input logic en,
                       input logic bu, input logic [7:0] bl,
                       input logic [7:0] est, input logic eb, input logic ed, input logic ew,
                       input logic el, input logic [7:0] ecnt, input logic [5:0] chk,
                       input string nm);
        exp_t e;
        reset           = rst;
        bus.load_i      = ld;
        bus.seed_i      = sd;
        bus.en_i        = en;
        bus.burst_i     = bu;
        bus.burst_len_i = bl;
        @(posedge clk);
        e.st = est; e.busy = eb; e.done = ed; e.wrap = ew; e.lock = el; e.cnt = ecnt; e.chk = chk;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus.load_i = 1'b0; bus.seed_i = 8'h00; bus.en_i = 1'b0;
        bus.burst_i = 1'b0; bus.burst_len_i = 8'h00;

        // reset defaults and idle hold
        cyc(1,0,8'h00,0,0,8'd0, 8'h01,0,0,0,0,8'd0, 6'h3F, "reset");
        cyc(0,0,8'h00,0,0,8'd0, 8'h01,0,0,0,0,8'd0, 6'h3F, "idle_hold");

        // single steps from the reset seed
        cyc(0,0,8'h00,1,0,8'd0, 8'h03,0,0,0,0,8'd1, 6'h3F, "en1");
        cyc(0,0,8'h00,1,0,8'd0, 8'h07,0,0,0,0,8'd2, 6'h3F, "en2");
        cyc(0,0,8'h00,1,0,8'd0, 8'h0F,0,0,0,0,8'd3, 6'h3F, "en3");
        cyc(0,0,8'h00,1,0,8'd0, 8'h1E,0,0,0,0,8'd4, 6'h3F, "en4");
        cyc(0,0,8'h00,0,0,8'd0, 8'h1E,0,0,0,0,8'd4, 6'h3F, "hold");

        // lock-up seed substitution
        cyc(0,1,8'hFF,0,0,8'd0, 8'h00,0,0,0,1,8'd0, 6'h3F, "load_ff");
        cyc(0,0,8'h00,1,0,8'd0, 8'h01,0,0,0,0,8'd1, 6'h3F, "step_from_00");

        // full period wrap
        cyc(0,1,8'h01,0,0,8'd0, 8'h01,0,0,0,0,8'd0, 6'h3F, "load_01");
        for (int i = 1; i <= 255; i++) begin
            if (i < 255) cyc(0,0,8'h00,1,0,8'd0, 8'h00,0,0,0,0,8'(i), 6'h28, "period");
            else         cyc(0,0,8'h00,1,0,8'd0, 8'h01,0,0,1,0,8'd0, 6'h3F, "wrap");
        end
        cyc(0,0,8'h00,1,0,8'd0, 8'h03,0,0,0,0,8'd1, 6'h3F, "after_wrap");

        // burst of 5 with en_i and a stray burst_i ignored while busy
        cyc(0,1,8'h01,0,0,8'd0, 8'h01,0,0,0,0,8'd0, 6'h3F, "reload_01");
        cyc(0,0,8'h00,1,1,8'd5, 8'h03,1,0,0,0,8'd1, 6'h3F, "burst_s1");
        cyc(0,0,8'h00,1,0,8'd5, 8'h07,1,0,0,0,8'd2, 6'h3F, "burst_s2");
        cyc(0,0,8'h00,1,1,8'd9, 8'h0F,1,0,0,0,8'd3, 6'h3F, "burst_s3");
        cyc(0,0,8'h00,1,0,8'd5, 8'h1E,1,0,0,0,8'd4, 6'h3F, "burst_s4");
        cyc(0,0,8'h00,0,0,8'd5, 8'h3D,0,1,0,0,8'd5, 6'h3F, "burst_done");
        cyc(0,0,8'h00,0,0,8'd0, 8'h3D,0,0,0,0,8'd5, 6'h3F, "burst_after");

        // long burst aborted by load
        for (int k = 1; k <= 10; k++)
            cyc(0,0,8'h00,0,(k == 1),8'd200, 8'h00,1,0,0,0,8'(5 + k), 6'h26, "long_burst");
        cyc(0,1,8'h5A,0,0,8'd0, 8'h5A,0,0,0,0,8'd0, 6'h3F, "abort_load");
        for (int k = 0; k < 5; k++)
            cyc(0,0,8'h00,0,0,8'd0, 8'h5A,0,0,0,0,8'd0, 6'h3F, "abort_nodone");

        // zero-length burst: done only, no step even with en_i high
        cyc(0,0,8'h00,1,1,8'd0, 8'h5A,0,1,0,0,8'd0, 6'h3F, "len0");
        cyc(0,0,8'h00,0,0,8'd0, 8'h5A,0,0,0,0,8'd0, 6'h3F, "len0_after");

        // reset in the middle of a burst
        cyc(0,0,8'h00,0,1,8'd50, 8'h00,1,0,0,0,8'd0, 6'h06, "rb1");
        cyc(0,0,8'h00,0,0,8'd50, 8'h00,1,0,0,0,8'd0, 6'h06, "rb2");
        cyc(1,0,8'h00,0,0,8'd0, 8'h01,0,0,0,0,8'd0, 6'h3F, "mid_reset");
        for (int k = 0; k < 3; k++)
            cyc(0,0,8'h00,0,0,8'd0, 8'h01,0,0,0,0,8'd0, 6'h07, "post_reset");

        // one-step burst finishes without busy
        cyc(0,0,8'h00,0,1,8'd1, 8'h03,0,1,0,0,8'd1, 6'h3F, "len1");
        cyc(0,0,8'h00,0,0,8'd0, 8'h03,0,0,0,0,8'd1, 6'h3F, "len1_after");

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
